// File: rtl/seg_time_disp.sv
// rtl/seg_time_disp.sv - 6-digit " MM.SS.D" 7-segment scan driver with frame snapshot and blink.
// Optional build macro SEG_LZB_EN: blank the minutes tens digit when minutes < 10.
module seg_time_disp #(
  parameter int unsigned SCAN_CNT_MAX  = 49_999,
  parameter int unsigned BLINK_CNT_MAX = 12_499_999
) (
  input  logic       sclk,
  input  logic       nrst,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [7:0] deci_sec,
  input  logic       blink_en,
  output logic [7:0] seg,
  output logic [5:0] sel
);

  localparam int SCAN_W  = (SCAN_CNT_MAX  > 0) ? $clog2(SCAN_CNT_MAX + 1)  : 1;
  localparam int BLINK_W = (BLINK_CNT_MAX > 0) ? $clog2(BLINK_CNT_MAX + 1) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CNT_MAX);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CNT_MAX);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         idx;
  logic [7:0]         min_q;
  logic [7:0]         sec_q;
  logic [7:0]         ds_q;
  logic               first;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  logic               scan_wrap;
  logic               snap_load;
  logic [BLINK_W-1:0] blink_cnt_nxt;
  logic               blink_phase_nxt;
  logic [7:0]         seg_nxt;
  logic [5:0]         sel_nxt;

  logic       min_bad;
  logic       sec_bad;
  logic       ds_bad;
  logic [3:0] min_t;
  logic [3:0] min_o;
  logic [3:0] sec_t;
  logic [3:0] sec_o;
  logic [3:0] ds_o;

  function automatic logic [7:0] digit_seg(input logic [3:0] d, input logic bad, input logic dp);
    logic [7:0] c;
    if (bad) begin
      c = 8'hBF;
    end else begin
      case (d)
        4'd0:    c = 8'hC0;
        4'd1:    c = 8'hF9;
        4'd2:    c = 8'hA4;
        4'd3:    c = 8'hB0;
        4'd4:    c = 8'h99;
        4'd5:    c = 8'h92;
        4'd6:    c = 8'h82;
        4'd7:    c = 8'hF8;
        4'd8:    c = 8'h80;
        4'd9:    c = 8'h90;
        default: c = 8'hFF;
      endcase
    end
    if (dp) c[7] = 1'b0;
    return c;
  endfunction

  assign scan_wrap = (scan_cnt == SCAN_LAST);
  // A new frame's values are captured exactly as the index returns to the blank digit.
  assign snap_load = first || (scan_wrap && (idx == 3'd5));

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      first <= 1'b1;
      min_q <= 8'd0;
      sec_q <= 8'd0;
      ds_q  <= 8'd0;
    end else begin
      first <= 1'b0;
      if (snap_load) begin
        min_q <= min;
        sec_q <= sec;
        ds_q  <= deci_sec;
      end
    end
  end

  always_comb begin
    blink_cnt_nxt   = blink_cnt;
    blink_phase_nxt = blink_phase;
    if (!blink_en) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = ~blink_phase;
    end else begin
      blink_cnt_nxt   = blink_cnt + BLINK_W'(1);
    end
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
    end
  end

  always_comb begin
    min_bad = (min_q > 8'd99);
    sec_bad = (sec_q > 8'd99);
    ds_bad  = (ds_q > 8'd9);
    min_t   = 4'(min_q / 8'd10);
    min_o   = 4'(min_q % 8'd10);
    sec_t   = 4'(sec_q / 8'd10);
    sec_o   = 4'(sec_q % 8'd10);
    ds_o    = 4'(ds_q % 8'd10);
    seg_nxt = 8'hFF;
    case (idx)
      3'd1: begin
`ifdef SEG_LZB_EN
        if (min_q < 8'd10) seg_nxt = 8'hFF;
        else               seg_nxt = digit_seg(min_t, min_bad, 1'b0);
`else
        seg_nxt = digit_seg(min_t, min_bad, 1'b0);
`endif
      end
      3'd2:    seg_nxt = digit_seg(min_o, min_bad, 1'b1);
      3'd3:    seg_nxt = digit_seg(sec_t, sec_bad, 1'b0);
      3'd4:    seg_nxt = digit_seg(sec_o, sec_bad, 1'b1);
      3'd5:    seg_nxt = digit_seg(ds_o, ds_bad, 1'b0);
      default: seg_nxt = 8'hFF;
    endcase
    sel_nxt = ~(6'b000001 << idx);
  end

  // Gating on the next phase keeps the dark window aligned with the phase register itself.
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      seg <= 8'hFF;
      sel <= 6'b111111;
    end else if (!blink_phase_nxt) begin
      seg <= 8'hFF;
      sel <= 6'b111111;
    end else begin
      seg <= seg_nxt;
      sel <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_seg_time_disp.sv
// tb/tb_seg_time_disp.sv - table-driven scoreboard bench for seg_time_disp.
// Honours SEG_LZB_EN for the minutes tens expectation.
module tb_seg_time_disp;

  logic       sclk = 1'b0;
  logic       nrst = 1'b1;
  logic [7:0] min = 8'd0;
  logic [7:0] sec = 8'd0;
  logic [7:0] deci_sec = 8'd0;
  logic       blink_en = 1'b0;
  logic [7:0] seg;
  logic [5:0] sel;

  seg_time_disp #(.SCAN_CNT_MAX(3), .BLINK_CNT_MAX(47)) dut (
    .sclk(sclk), .nrst(nrst), .min(min), .sec(sec), .deci_sec(deci_sec),
    .blink_en(blink_en), .seg(seg), .sel(sel)
  );

  always #5 sclk = ~sclk;

`ifdef SEG_LZB_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  typedef struct packed {
    logic [7:0]      m;
    logic [7:0]      s;
    logic [7:0]      d;
    logic [0:5][7:0] e;
  } vec_t;

  vec_t        vecs [7];
  logic [13:0] exp_q [$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic push_frame(input logic [0:5][7:0] e);
    logic [5:0] s;
    for (int i = 0; i < 6; i++) begin
      s = ~(6'b000001 << i);
      exp_q.push_back({s, e[i]});
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge sclk);
      n++;
    end
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_sel(input logic [5:0] target, input int budget);
    int n = 0;
    do begin
      @(posedge sclk);
      #1;
      n++;
    end while (sel !== target && n < budget);
    if (sel !== target) begin
      n_checks++;
      $display("FAIL wait_sel: got %b want %b", sel, target);
    end
  endtask

  task automatic reset_with(input logic [7:0] m, input logic [7:0] s, input logic [7:0] d);
    @(negedge sclk);
    nrst = 1'b0;
    min = m;
    sec = s;
    deci_sec = d;
    @(negedge sclk);
  endtask

  task automatic release_rst();
    nrst = 1'b1;
  endtask

  function automatic logic [1:0] vis_state(input logic [5:0] sv, input logic [7:0] gv);
    if (sv == 6'h3F && gv == 8'hFF) return 2'd0;
    if ($countones(~sv) == 1)        return 2'd1;
    return 2'd2;
  endfunction

  // Scoreboard monitor: each new digit select pops one expected {sel,seg}.
  initial begin
    logic [5:0]  prev;
    logic [13:0] e;
    int          hold;
    prev = 6'h3F;
    hold = 0;
    forever begin
      @(posedge sclk);
      #1;
      if (sel !== prev) begin
        if (exp_q.size() > 0 && sel !== 6'h3F) begin
          e = exp_q.pop_front();
          if (prev !== 6'h3F) check("hold", 32'(hold), 32'd4);
          check("digit", 32'({sel, seg}), 32'(e));
        end
        prev = sel;
        hold = 1;
      end else begin
        hold++;
      end
    end
  end

  initial begin
    logic [1:0] want;
    vecs[0] = '{m: 8'd12,  s: 8'd34,  d: 8'd5,   e: {8'hFF, 8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92}};
    vecs[1] = '{m: 8'd100, s: 8'd59,  d: 8'd12,  e: {8'hFF, 8'hBF, 8'h3F, 8'h92, 8'h10, 8'hBF}};
    vecs[2] = '{m: 8'd7,   s: 8'd0,   d: 8'd0,   e: {8'hFF, LZ,    8'h78, 8'hC0, 8'h40, 8'hC0}};
    vecs[3] = '{m: 8'd99,  s: 8'd99,  d: 8'd9,   e: {8'hFF, 8'h90, 8'h10, 8'h90, 8'h10, 8'h90}};
    vecs[4] = '{m: 8'd0,   s: 8'd100, d: 8'd10,  e: {8'hFF, LZ,    8'h40, 8'hBF, 8'h3F, 8'hBF}};
    vecs[5] = '{m: 8'd86,  s: 8'd7,   d: 8'd3,   e: {8'hFF, 8'h80, 8'h02, 8'hC0, 8'h78, 8'hB0}};
    vecs[6] = '{m: 8'd255, s: 8'd10,  d: 8'd255, e: {8'hFF, 8'hBF, 8'h3F, 8'hF9, 8'h40, 8'hBF}};

    #2;
    nrst = 1'b0;
    #1;
    check("reset_seg", 32'(seg), 32'hFF);
    check("reset_sel", 32'(sel), 32'h3F);

    for (int v = 0; v < 7; v++) begin
      reset_with(vecs[v].m, vecs[v].s, vecs[v].d);
      push_frame(vecs[v].e);
      release_rst();
      wait_drain(60);
    end

    // Mid-frame input change must wait for the next frame snapshot.
    reset_with(8'd12, 8'd34, 8'd5);
    push_frame({8'hFF, 8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92});
    push_frame({8'hFF, 8'hF9, 8'h24, 8'hB0, 8'h12, 8'h92});
    release_rst();
    wait_sel(6'b110111, 40);
    sec = 8'd35;
    wait_drain(100);

    // Asynchronous reset mid-frame, then a fresh frame with the new inputs.
    reset_with(8'd12, 8'd34, 8'd5);
    release_rst();
    wait_sel(6'b110111, 40);
    min = 8'd45;
    sec = 8'd6;
    deci_sec = 8'd8;
    #3;
    nrst = 1'b0;
    #1;
    check("async_seg", 32'(seg), 32'hFF);
    check("async_sel", 32'(sel), 32'h3F);
    @(negedge sclk);
    check("held_sel", 32'(sel), 32'h3F);
    push_frame({8'hFF, 8'h99, 8'h12, 8'hC0, 8'h02, 8'h80});
    @(negedge sclk);
    release_rst();
    wait_drain(60);

    // Blink: dark during 48..95 and 144..191 after enable.
    @(posedge sclk);
    #1;
    blink_en = 1'b1;
    for (int j = 1; j <= 200; j++) begin
      @(posedge sclk);
      #1;
      want = ((j >= 48 && j <= 95) || (j >= 144 && j <= 191)) ? 2'd0 : 2'd1;
      check($sformatf("blink_%0d", j), 32'(vis_state(sel, seg)), 32'(want));
    end
    blink_en = 1'b0;
    for (int j = 201; j <= 205; j++) begin
      @(posedge sclk);
      #1;
      check("blink_off", 32'(vis_state(sel, seg)), 32'd1);
    end

    // Re-enable restarts a full visible half-period; dropping in the dark shows next cycle.
    blink_en = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      @(posedge sclk);
      #1;
      want = (j >= 48) ? 2'd0 : 2'd1;
      check($sformatf("reblink_%0d", j), 32'(vis_state(sel, seg)), 32'(want));
    end
    blink_en = 1'b0;
    @(posedge sclk);
    #1;
    check("blink_drop", 32'(vis_state(sel, seg)), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
